approx_mul_err_eval: RTL and testbench

- Closed-loop error characteriser for the 8x8 approximate multipliers, i.e. their four-quadrant-composed variants.
- Acts as the driving end of the multiplier interface: it sources every operand pair on a/b outputs and consumes the candidate's combinational product.
- Compares each product against an internal exact product and accumulates error statistics over the full 2^(2W) operand space.
- Sits beside the multiplier under test in the evaluation top; results are read after done.

---
 rtl/approx_mul_err_eval.sv | 131 +++++++++++++
 tb/tb_approx_mul_err_eval.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_eval.sv
// Closed-loop error characteriser for approximate WxW multipliers.
// Sweeps every operand pair, compares the candidate's product against an
// internal exact product and accumulates error statistics.
module approx_mul_err_eval #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic [W-1:0]   op_a,
   output logic [W-1:0]   op_b,
   input  logic [2*W-1:0] approx_prod,
   output logic           busy,
   output logic           done,
   output logic [2*W:0]   err_count,
   output logic [2*W-1:0] max_abs_err,
   output logic [W-1:0]   max_a,
   output logic [W-1:0]   max_b,
   output logic [4*W-1:0] sum_abs_err,
   output logic [4*W:0]   sum_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]     state;
   logic           drain_cnt;
   logic [2*W-1:0] pair;       // sweep counter, doubles as the operand register
   logic           go;

   // stage 1 registers
   logic           vld1;
   logic [2*W-1:0] ap1, ex1;
   logic [W-1:0]   a1, b1;

   logic [2*W-1:0] exact;
   logic [2*W:0]   err, err_neg;
   logic [2*W-1:0] abs_err;

   assign op_a  = pair[2*W-1:W];
   assign op_b  = pair[W-1:0];
   assign busy  = (state == S_SWEEP) || (state == S_DRAIN);
   assign done  = (state == S_DONE);
   assign go    = start && ((state == S_IDLE) || (state == S_DONE));
   assign exact = (2*W)'(op_a) * (2*W)'(op_b);

   // stage 2 error terms; the 2W+1 bit difference cannot overflow
   assign err     = {1'b0, ap1} - {1'b0, ex1};
   assign err_neg = -err;
   assign abs_err = err[2*W] ? err_neg[2*W-1:0] : err[2*W-1:0];

   // sequencer: IDLE/DONE -> SWEEP over all pairs -> 2-cycle DRAIN -> DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         drain_cnt <= 1'b0;
         pair      <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (go) begin
                  state <= S_SWEEP;
                  pair  <= '0;
               end
            end
            S_SWEEP: begin
               // last pair is captured by stage 1 on this edge; hold operands
               if (pair == {(2*W){1'b1}}) begin
                  state     <= S_DRAIN;
                  drain_cnt <= 1'b0;
               end else begin
                  pair <= pair + 1'b1;
               end
            end
            default: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) state <= S_DONE;
            end
         endcase
      end
   end

   // stage 1: capture candidate product, exact product and operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld1 <= 1'b0;
         ap1  <= '0;
         ex1  <= '0;
         a1   <= '0;
         b1   <= '0;
      end else begin
         vld1 <= (state == S_SWEEP);
         ap1  <= approx_prod;
         ex1  <= exact;
         a1   <= op_a;
         b1   <= op_b;
      end
   end

   // stage 2: accumulate statistics; cleared on the start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count   <= '0;
         max_abs_err <= '0;
         max_a       <= '0;
         max_b       <= '0;
         sum_abs_err <= '0;
         sum_err     <= '0;
      end else if (go) begin
         err_count   <= '0;
         max_abs_err <= '0;
         max_a       <= '0;
         max_b       <= '0;
         sum_abs_err <= '0;
         sum_err     <= '0;
      end else if (vld1) begin
         err_count   <= err_count + {{(2*W){1'b0}}, (abs_err != '0)};
         sum_abs_err <= sum_abs_err + {{(2*W){1'b0}}, abs_err};
         sum_err     <= sum_err + {{(2*W){err[2*W]}}, err};
         // strict compare keeps the earliest pair on ties
         if (abs_err > max_abs_err) begin
            max_abs_err <= abs_err;
            max_a       <= a1;
            max_b       <= b1;
         end
      end
   end

endmodule

// File: tb/tb_approx_mul_err_eval.sv
// Directed bench: a W=8 instance for one full LSB-clear sweep and a W=2
// instance for the remaining scenarios, each with hand-computed results.
module tb_approx_mul_err_eval;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // W=8 instance
   logic        start8;
   logic [7:0]  op_a8, op_b8, max_a8, max_b8;
   logic [15:0] prod8, max_abs8;
   logic        busy8, done8;
   logic [16:0] errc8;
   logic [31:0] sabs8;
   logic [32:0] serr8;

   // W=2 instance
   logic        start2;
   logic [1:0]  op_a2, op_b2, max_a2, max_b2;
   logic [3:0]  prod2, max_abs2;
   logic        busy2, done2;
   logic [4:0]  errc2;
   logic [7:0]  sabs2;
   logic [8:0]  serr2;

   int mode2;   // 0 exact, 1 lsb-clear, 2 stuck-zero, 3 exact+1

   approx_mul_err_eval #(.W(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .op_a(op_a8), .op_b(op_b8),
      .approx_prod(prod8), .busy(busy8), .done(done8), .err_count(errc8),
      .max_abs_err(max_abs8), .max_a(max_a8), .max_b(max_b8),
      .sum_abs_err(sabs8), .sum_err(serr8));

   approx_mul_err_eval #(.W(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2),
      .approx_prod(prod2), .busy(busy2), .done(done2), .err_count(errc2),
      .max_abs_err(max_abs2), .max_a(max_a2), .max_b(max_b2),
      .sum_abs_err(sabs2), .sum_err(serr2));

   // multipliers under test
   always_comb begin
      logic [15:0] p8;
      p8    = 16'(op_a8) * 16'(op_b8);
      prod8 = p8 & 16'hFFFE;
   end

   always_comb begin
      logic [3:0] p2;
      p2 = 4'(op_a2) * 4'(op_b2);
      case (mode2)
         1:       prod2 = p2 & 4'hE;
         2:       prod2 = 4'h0;
         3:       prod2 = p2 + 4'h1;
         default: prod2 = p2;
      endcase
   end

   // start a W=2 sweep and count edges (start edge included) until done
   task automatic sweep2(output int edges);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      edges = 1;
      while (!done2 && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start8 = 1'b0; start2 = 1'b0; mode2 = 0;
      repeat (2) @(posedge clk);
      #1;
      total++; if ({busy2, done2, op_a2, op_b2} !== 6'd0) begin bad++; $display("FAIL reset_ctl2 got=%h want=0", {busy2, done2, op_a2, op_b2}); end
      total++; if ({errc2, max_abs2, max_a2, max_b2, sabs2, serr2} !== '0) begin bad++; $display("FAIL reset_stats2 got=nonzero want=0"); end
      total++; if ({busy8, done8, errc8, max_abs8, sabs8, serr8} !== '0) begin bad++; $display("FAIL reset_8 got=nonzero want=0"); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_exact2;
      int e;
      mode2 = 0;
      sweep2(e);
      total++; if (e !== 19) begin bad++; $display("FAIL exact2_edges got=%0d want=19", e); end
      total++; if ({errc2, max_abs2, max_a2, max_b2, sabs2, serr2} !== '0) begin bad++; $display("FAIL exact2_stats got=%0d/%0d want=0/0", errc2, max_abs2); end
      total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL exact2_busy got=%b want=0", busy2); end
   endtask

   task automatic test_sweep_order;
      mode2 = 0;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      total++; if ({op_a2, op_b2, busy2} !== 5'b0000_1) begin bad++; $display("FAIL order_p0 got=%b want=00001", {op_a2, op_b2, busy2}); end
      repeat (6) @(posedge clk);
      #1;
      // six edges past the start edge -> pair 6 = a1,b2
      total++; if ({op_a2, op_b2} !== 4'b0110) begin bad++; $display("FAIL order_p6 got=%b want=0110", {op_a2, op_b2}); end
      repeat (20) @(posedge clk);
      #1;
      total++; if (done2 !== 1'b1) begin bad++; $display("FAIL order_done got=%b want=1", done2); end
   endtask

   task automatic test_stuck_zero2;
      int e;
      mode2 = 2;
      sweep2(e);
      total++; if (e !== 19) begin bad++; $display("FAIL zero2_edges got=%0d want=19", e); end
      total++; if (errc2 !== 5'd9) begin bad++; $display("FAIL zero2_count got=%0d want=9", errc2); end
      total++; if ({max_abs2, max_a2, max_b2} !== {4'd9, 2'd3, 2'd3}) begin bad++; $display("FAIL zero2_max got=%0d@%0d,%0d want=9@3,3", max_abs2, max_a2, max_b2); end
      total++; if (sabs2 !== 8'd36) begin bad++; $display("FAIL zero2_sabs got=%0d want=36", sabs2); end
      total++; if ($signed(serr2) !== -36) begin bad++; $display("FAIL zero2_serr got=%0d want=-36", $signed(serr2)); end
   endtask

   task automatic test_lsb_clear2;
      int e;
      mode2 = 1;
      sweep2(e);
      total++; if (errc2 !== 5'd4) begin bad++; $display("FAIL lsb2_count got=%0d want=4", errc2); end
      total++; if ({max_abs2, max_a2, max_b2} !== {4'd1, 2'd1, 2'd1}) begin bad++; $display("FAIL lsb2_max got=%0d@%0d,%0d want=1@1,1", max_abs2, max_a2, max_b2); end
      total++; if (sabs2 !== 8'd4 || $signed(serr2) !== -4) begin bad++; $display("FAIL lsb2_sums got=%0d/%0d want=4/-4", sabs2, $signed(serr2)); end
   endtask

   task automatic test_plus_one2;
      int e;
      mode2 = 3;
      sweep2(e);
      total++; if (errc2 !== 5'd16) begin bad++; $display("FAIL plus2_count got=%0d want=16", errc2); end
      total++; if ({max_abs2, max_a2, max_b2} !== {4'd1, 2'd0, 2'd0}) begin bad++; $display("FAIL plus2_max got=%0d@%0d,%0d want=1@0,0", max_abs2, max_a2, max_b2); end
      total++; if (sabs2 !== 8'd16 || $signed(serr2) !== 16) begin bad++; $display("FAIL plus2_sums got=%0d/%0d want=16/16", sabs2, $signed(serr2)); end
   endtask

   task automatic test_reset_mid;
      int e;
      mode2 = 3;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      total++; if (errc2 === 5'd0) begin bad++; $display("FAIL mid_pre_count got=%0d want=nonzero", errc2); end
      rst = 1'b1;
      #1;
      total++; if ({busy2, done2, op_a2, op_b2, errc2, sabs2, serr2, max_abs2} !== '0) begin bad++; $display("FAIL mid_async_clear got=busy%b cnt%0d want=0", busy2, errc2); end
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if ({busy2, done2} !== 2'b00) begin bad++; $display("FAIL mid_idle got=%b want=00", {busy2, done2}); end
      sweep2(e);
      total++; if (e !== 19 || errc2 !== 5'd16 || sabs2 !== 8'd16 || $signed(serr2) !== 16) begin bad++; $display("FAIL mid_rerun got=%0d/%0d/%0d want=19/16/16", e, errc2, sabs2); end
   endtask

   task automatic test_start_held;
      int e;
      mode2 = 2;
      start2 = 1'b1;
      @(posedge clk); #1;
      e = 1;
      // keep start high through SWEEP/DRAIN; drop it before DONE
      while (e < 18) begin
         @(posedge clk); #1;
         e++;
         if (e == 17) start2 = 1'b0;
      end
      total++; if (busy2 !== 1'b1 || done2 !== 1'b0) begin bad++; $display("FAIL held_busy got=%b%b want=10", busy2, done2); end
      @(posedge clk); #1;
      e++;
      total++; if (e !== 19 || done2 !== 1'b1) begin bad++; $display("FAIL held_done got=%0d/%b want=19/1", e, done2); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (done2 !== 1'b1 || errc2 !== 5'd9) begin bad++; $display("FAIL held_hold got=%b/%0d want=1/9", done2, errc2); end
      // restart from DONE
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      total++; if (errc2 !== 5'd0 || busy2 !== 1'b1 || done2 !== 1'b0) begin bad++; $display("FAIL restart_clear got=%0d/%b%b want=0/10", errc2, busy2, done2); end
      e = 1;
      while (!done2 && e < 100) begin
         @(posedge clk); #1;
         e++;
      end
      total++; if (e !== 19 || errc2 !== 5'd9 || sabs2 !== 8'd36 || max_abs2 !== 4'd9) begin bad++; $display("FAIL restart_rerun got=%0d/%0d/%0d want=19/9/36", e, errc2, sabs2); end
   endtask

   task automatic test_lsb_clear8;
      int e;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      e = 1;
      while (!done8 && e < 70000) begin
         @(posedge clk); #1;
         e++;
      end
      total++; if (e !== 65539) begin bad++; $display("FAIL lsb8_edges got=%0d want=65539", e); end
      total++; if (errc8 !== 17'd16384) begin bad++; $display("FAIL lsb8_count got=%0d want=16384", errc8); end
      total++; if ({max_abs8, max_a8, max_b8} !== {16'd1, 8'd1, 8'd1}) begin bad++; $display("FAIL lsb8_max got=%0d@%0d,%0d want=1@1,1", max_abs8, max_a8, max_b8); end
      total++; if (sabs8 !== 32'd16384) begin bad++; $display("FAIL lsb8_sabs got=%0d want=16384", sabs8); end
      total++; if ($signed(serr8) !== -16384) begin bad++; $display("FAIL lsb8_serr got=%0d want=-16384", $signed(serr8)); end
   endtask

   initial begin
      test_reset;
      test_exact2;
      test_sweep_order;
      test_stuck_zero2;
      test_lsb_clear2;
      test_plus_one2;
      test_reset_mid;
      test_start_held;
      test_lsb_clear8;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
